// File: rtl/instruction_fetcher_pkg.sv
// Shared constants, state encodings and cache payload types for the fetch stage.
package instruction_fetcher_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned ICACHE_IDX_WIDTH = 6;
  localparam int unsigned ICACHE_LINES     = 1 << ICACHE_IDX_WIDTH;
  localparam int unsigned ICACHE_TAG_WIDTH = XLEN - ICACHE_IDX_WIDTH - 2;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Fetch FSM encodings (kept as plain constants for legacy compatibility)
  localparam logic [1:0] IF_IDLE   = 2'd0;
  localparam logic [1:0] IF_BUBBLE = 2'd1;
  localparam logic [1:0] IF_MISS   = 2'd2;

  // One cache line write: where, which tag, what word
  typedef struct packed {
    logic [ICACHE_IDX_WIDTH-1:0] idx;
    logic [ICACHE_TAG_WIDTH-1:0] tag;
    logic [XLEN-1:0]             data;
  } icache_wr_t;

endpackage

// File: rtl/instruction_fetcher_if.sv
// Instruction read channel between the fetch stage and the memory controller.
//   mem_req  - read request, held until the matching mem_done
//   mem_addr - word-aligned request address
//   mem_done - one-cycle pulse, mem_data valid
//   mem_data - returned instruction word
interface instruction_fetcher_if;
  import instruction_fetcher_pkg::*;

  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_done;
  logic [XLEN-1:0] mem_data;

  modport master (output mem_req, mem_addr, input mem_done, mem_data);
  modport slave  (input mem_req, mem_addr, output mem_done, mem_data);
endinterface

// File: rtl/instruction_fetcher_icache_array.sv
// Direct-mapped one-word-per-line instruction cache storage.
//   rd_idx/rd_tag -> rd_hit_c/rd_data_c : combinational lookup
//   wr_en/wr      : synchronous line fill
//   rst_in        : asynchronously clears every valid bit
module icache_array
  import instruction_fetcher_pkg::*;
(
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [ICACHE_IDX_WIDTH-1:0] rd_idx,
  input  logic [ICACHE_TAG_WIDTH-1:0] rd_tag,
  output logic                        rd_hit_c,
  output logic [XLEN-1:0]             rd_data_c,
  input  logic                        wr_en,
  input  icache_wr_t                  wr
);

  logic [XLEN-1:0]             data_q  [ICACHE_LINES];
  logic [ICACHE_TAG_WIDTH-1:0] tag_q   [ICACHE_LINES];
  logic [ICACHE_LINES-1:0]     valid_q;

  // Valid bits carry the only state that must be reset
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr.idx] <= TRUE;
    end
  end

  // Data and tag need no reset: they are qualified by valid
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      data_q[wr.idx] <= wr.data;
      tag_q[wr.idx]  <= wr.tag;
    end
  end

  assign rd_hit_c  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_data_c = data_q[rd_idx];

endmodule

// File: rtl/instruction_fetcher.sv
// Fetch stage: looks pc_in up in the instruction cache, issues one word per
// hit with a single-cycle pulse, and refills from memory on a miss.
//   clk_in, rst_in (async, active-high), rdy_in (global pause)
//   pc_in, stop_fetching, roll_back, iq_full : control from BTB / queue
//   fetch_new_instruction, inst_out, inst_pc : issue to decoder
//   mem_if (master)                          : memory read channel
module instruction_fetcher
  import instruction_fetcher_pkg::*;
(
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic [XLEN-1:0]              pc_in,
  input  logic                         stop_fetching,
  input  logic                         roll_back,
  input  logic                         iq_full,
  output logic                         fetch_new_instruction,
  output logic [XLEN-1:0]              inst_out,
  output logic [XLEN-1:0]              inst_pc,
  instruction_fetcher_if.master        mem_if
);

  logic [1:0]      state_q, state_nxt;
  logic            fetch_q, fetch_nxt;
  logic [XLEN-1:0] inst_q, inst_nxt;
  logic [XLEN-1:0] ipc_q, ipc_nxt;
  logic            req_q, req_nxt;
  logic [XLEN-1:0] addr_q, addr_nxt;
  logic            fill_c;

  logic            hit_c;
  logic [XLEN-1:0] hit_data_c;
  icache_wr_t      wr_c;

  // Fill always targets the line of the outstanding request address
  assign wr_c.idx  = addr_q[ICACHE_IDX_WIDTH+1:2];
  assign wr_c.tag  = addr_q[XLEN-1:ICACHE_IDX_WIDTH+2];
  assign wr_c.data = mem_if.mem_data;

  icache_array u_icache (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rd_idx    (pc_in[ICACHE_IDX_WIDTH+1:2]),
    .rd_tag    (pc_in[XLEN-1:ICACHE_IDX_WIDTH+2]),
    .rd_hit_c  (hit_c),
    .rd_data_c (hit_data_c),
    .wr_en     (fill_c && rdy_in),
    .wr        (wr_c)
  );

  // State and output registers; rdy_in low freezes everything
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IF_IDLE;
      fetch_q <= FALSE;
      inst_q  <= '0;
      ipc_q   <= '0;
      req_q   <= FALSE;
      addr_q  <= '0;
    end else if (rdy_in) begin
      state_q <= state_nxt;
      fetch_q <= fetch_nxt;
      inst_q  <= inst_nxt;
      ipc_q   <= ipc_nxt;
      req_q   <= req_nxt;
      addr_q  <= addr_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state_q;
    fetch_nxt = FALSE;
    inst_nxt  = inst_q;
    ipc_nxt   = ipc_q;
    req_nxt   = req_q;
    addr_nxt  = addr_q;
    fill_c    = FALSE;
    case (state_q)
      IF_IDLE: begin
        if (roll_back) begin
          state_nxt = IF_BUBBLE;
        end else if (stop_fetching || iq_full) begin
          state_nxt = IF_IDLE;
        end else if (hit_c) begin
          fetch_nxt = TRUE;
          inst_nxt  = hit_data_c;
          ipc_nxt   = pc_in;
          state_nxt = IF_BUBBLE;
        end else begin
          req_nxt   = TRUE;
          addr_nxt  = {pc_in[XLEN-1:2], 2'b00};
          state_nxt = IF_MISS;
        end
      end
      // Dead cycle so the BTB can advance pc_in before the next lookup
      IF_BUBBLE: begin
        state_nxt = roll_back ? IF_BUBBLE : IF_IDLE;
      end
      // A roll_back here does not abort: the line is valid for its address
      IF_MISS: begin
        if (mem_if.mem_done) begin
          fill_c    = TRUE;
          req_nxt   = FALSE;
          state_nxt = IF_IDLE;
        end
      end
      default: begin
        state_nxt = IF_IDLE;
      end
    endcase
  end

  assign fetch_new_instruction = fetch_q;
  assign inst_out              = inst_q;
  assign inst_pc               = ipc_q;
  assign mem_if.mem_req        = req_q;
  assign mem_if.mem_addr       = addr_q;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed self-checking bench for instruction_fetcher.
module tb_instruction_fetcher;
  import instruction_fetcher_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] pc_in;
  logic        stop_fetching;
  logic        roll_back;
  logic        iq_full;
  logic        fetch_new_instruction;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;

  instruction_fetcher_if mem_if ();

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk_in = ~clk_in;

  instruction_fetcher dut (
    .clk_in                (clk_in),
    .rst_in                (rst_in),
    .rdy_in                (rdy_in),
    .pc_in                 (pc_in),
    .stop_fetching         (stop_fetching),
    .roll_back             (roll_back),
    .iq_full               (iq_full),
    .fetch_new_instruction (fetch_new_instruction),
    .inst_out              (inst_out),
    .inst_pc               (inst_pc),
    .mem_if                (mem_if.master)
  );

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic park;
    stop_fetching = 1'b1;
    tick();
    tick();
  endtask

  // Memory responder: wait for mem_req, then pulse mem_done after lat cycles
  task automatic serve(input int lat, input logic [31:0] data, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !mem_if.mem_req; i++) tick();
    if (mem_if.mem_req) begin
      repeat (lat) tick();
      mem_if.mem_done = 1'b1;
      mem_if.mem_data = data;
      tick();
      mem_if.mem_done = 1'b0;
      ok = 1'b1;
    end
  endtask

  // Miss, fill and issue one line, then park the fetcher
  task automatic fill_line(input logic [31:0] pc, input logic [31:0] data, output bit ok);
    bit s;
    pc_in = pc;
    stop_fetching = 1'b0;
    tick();
    serve(1, data, s);
    tick();
    ok = s && fetch_new_instruction && (inst_pc == pc);
    stop_fetching = 1'b1;
  endtask

  task automatic test_reset;
    rst_in = 1'b1; rdy_in = 1'b1; pc_in = 32'h0;
    stop_fetching = 1'b1; roll_back = 1'b0; iq_full = 1'b0;
    mem_if.mem_done = 1'b0; mem_if.mem_data = 32'h0;
    #2;
    vectors++; if (fetch_new_instruction !== 1'b0) begin miscompares++; $display("FAIL reset_fetch: got %b want 0", fetch_new_instruction); end
    vectors++; if (inst_out !== 32'h0) begin miscompares++; $display("FAIL reset_inst_out: got %h want 0", inst_out); end
    vectors++; if (inst_pc !== 32'h0) begin miscompares++; $display("FAIL reset_inst_pc: got %h want 0", inst_pc); end
    vectors++; if (mem_if.mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req: got %b want 0", mem_if.mem_req); end
    vectors++; if (mem_if.mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_mem_addr: got %h want 0", mem_if.mem_addr); end
    tick();
    tick();
    rst_in = 1'b0;
    tick();
  endtask

  task automatic test_cold_miss;
    pc_in = 32'h0;
    stop_fetching = 1'b0;
    tick();
    vectors++; if (mem_if.mem_req !== 1'b1) begin miscompares++; $display("FAIL cold_req: got %b want 1", mem_if.mem_req); end
    vectors++; if (mem_if.mem_addr !== 32'h0) begin miscompares++; $display("FAIL cold_addr: got %h want 0", mem_if.mem_addr); end
    repeat (4) tick();
    vectors++; if (mem_if.mem_req !== 1'b1 || fetch_new_instruction !== 1'b0) begin miscompares++; $display("FAIL cold_wait: req %b fetch %b want 1/0", mem_if.mem_req, fetch_new_instruction); end
    mem_if.mem_done = 1'b1;
    mem_if.mem_data = 32'h00500093;
    tick();
    mem_if.mem_done = 1'b0;
    vectors++; if (mem_if.mem_req !== 1'b0 || fetch_new_instruction !== 1'b0) begin miscompares++; $display("FAIL cold_fill: req %b fetch %b want 0/0", mem_if.mem_req, fetch_new_instruction); end
    tick();
    vectors++; if (fetch_new_instruction !== 1'b1 || inst_out !== 32'h00500093 || inst_pc !== 32'h0) begin
      miscompares++; $display("FAIL cold_issue: fetch %b inst %h pc %h want 1/00500093/0", fetch_new_instruction, inst_out, inst_pc); end
    stop_fetching = 1'b1;
    tick();
    vectors++; if (fetch_new_instruction !== 1'b0) begin miscompares++; $display("FAIL cold_single_pulse: got %b want 0", fetch_new_instruction); end
  endtask

  task automatic test_hit_streaming;
    logic [31:0] exp_pc [3];
    logic [31:0] exp_in [3];
    bit ok;
    int k;
    exp_pc = '{32'h0, 32'h4, 32'h8};
    exp_in = '{32'h00500093, 32'h00100113, 32'h00200193};
    park();
    fill_line(32'h4, 32'h00100113, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL preload_4: got ok=%0d want 1", ok); end
    park();
    fill_line(32'h8, 32'h00200193, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL preload_8: got ok=%0d want 1", ok); end
    park();
    pc_in = 32'h0;
    stop_fetching = 1'b0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      vectors++; if (fetch_new_instruction !== ((c % 2) == 0)) begin miscompares++; $display("FAIL stream_pulse c%0d: got %b want %b", c, fetch_new_instruction, (c % 2) == 0); end
      vectors++; if (mem_if.mem_req !== 1'b0) begin miscompares++; $display("FAIL stream_no_req c%0d: got %b want 0", c, mem_if.mem_req); end
      if (fetch_new_instruction && k < 3) begin
        vectors++; if (inst_pc !== exp_pc[k] || inst_out !== exp_in[k]) begin
          miscompares++; $display("FAIL stream_word %0d: pc %h inst %h want %h/%h", k, inst_pc, inst_out, exp_pc[k], exp_in[k]); end
        k++;
        pc_in = pc_in + 32'h4;
        if (k == 3) stop_fetching = 1'b1;
      end
    end
    vectors++; if (k != 3) begin miscompares++; $display("FAIL stream_count: got %0d want 3", k); end
  endtask

  task automatic test_stall;
    park();
    pc_in = 32'h4;
    for (int c = 0; c < 4; c++) begin
      tick();
      vectors++; if (fetch_new_instruction !== 1'b0) begin miscompares++; $display("FAIL stall_stop c%0d: got %b want 0", c, fetch_new_instruction); end
    end
    stop_fetching = 1'b0;
    tick();
    vectors++; if (fetch_new_instruction !== 1'b1 || inst_pc !== 32'h4) begin miscompares++; $display("FAIL stall_stop_release: fetch %b pc %h want 1/4", fetch_new_instruction, inst_pc); end
    iq_full = 1'b1;
    pc_in = 32'h8;
    tick();
    for (int c = 0; c < 4; c++) begin
      tick();
      vectors++; if (fetch_new_instruction !== 1'b0) begin miscompares++; $display("FAIL stall_iq c%0d: got %b want 0", c, fetch_new_instruction); end
    end
    iq_full = 1'b0;
    tick();
    vectors++; if (fetch_new_instruction !== 1'b1 || inst_pc !== 32'h8 || inst_out !== 32'h00200193) begin
      miscompares++; $display("FAIL stall_iq_release: fetch %b pc %h inst %h want 1/8/00200193", fetch_new_instruction, inst_pc, inst_out); end
    stop_fetching = 1'b1;
  endtask

  task automatic test_roll_back_idle;
    park();
    pc_in = 32'h4;
    stop_fetching = 1'b0;
    roll_back = 1'b1;
    tick();
    roll_back = 1'b0;
    vectors++; if (fetch_new_instruction !== 1'b0) begin miscompares++; $display("FAIL rb_idle_suppress: got %b want 0", fetch_new_instruction); end
    tick();
    vectors++; if (fetch_new_instruction !== 1'b0) begin miscompares++; $display("FAIL rb_idle_bubble: got %b want 0", fetch_new_instruction); end
    tick();
    vectors++; if (fetch_new_instruction !== 1'b1 || inst_pc !== 32'h4) begin miscompares++; $display("FAIL rb_idle_issue: fetch %b pc %h want 1/4", fetch_new_instruction, inst_pc); end
    stop_fetching = 1'b1;
  endtask

  task automatic test_roll_back_miss;
    bit ok;
    park();
    fill_line(32'h80, 32'h00800213, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL preload_80: got ok=%0d want 1", ok); end
    park();
    pc_in = 32'h40;
    stop_fetching = 1'b0;
    tick();
    vectors++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 32'h40) begin miscompares++; $display("FAIL rbm_req: req %b addr %h want 1/40", mem_if.mem_req, mem_if.mem_addr); end
    roll_back = 1'b1;
    pc_in = 32'h80;
    tick();
    roll_back = 1'b0;
    vectors++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 32'h40 || fetch_new_instruction !== 1'b0) begin
      miscompares++; $display("FAIL rbm_hold: req %b addr %h fetch %b want 1/40/0", mem_if.mem_req, mem_if.mem_addr, fetch_new_instruction); end
    tick();
    mem_if.mem_done = 1'b1;
    mem_if.mem_data = 32'h00400213;
    tick();
    mem_if.mem_done = 1'b0;
    vectors++; if (mem_if.mem_req !== 1'b0 || fetch_new_instruction !== 1'b0) begin miscompares++; $display("FAIL rbm_fill: req %b fetch %b want 0/0", mem_if.mem_req, fetch_new_instruction); end
    tick();
    vectors++; if (fetch_new_instruction !== 1'b1 || inst_pc !== 32'h80 || inst_out !== 32'h00800213) begin
      miscompares++; $display("FAIL rbm_redirect: fetch %b pc %h inst %h want 1/80/00800213", fetch_new_instruction, inst_pc, inst_out); end
    park();
    pc_in = 32'h40;
    stop_fetching = 1'b0;
    tick();
    vectors++; if (fetch_new_instruction !== 1'b1 || inst_out !== 32'h00400213 || mem_if.mem_req !== 1'b0) begin
      miscompares++; $display("FAIL rbm_line_kept: fetch %b inst %h req %b want 1/00400213/0", fetch_new_instruction, inst_out, mem_if.mem_req); end
    stop_fetching = 1'b1;
  endtask

  task automatic test_conflict;
    bit ok;
    park();
    pc_in = 32'h100;
    stop_fetching = 1'b0;
    tick();
    vectors++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 32'h100 || fetch_new_instruction !== 1'b0) begin
      miscompares++; $display("FAIL conf_miss: req %b addr %h fetch %b want 1/100/0", mem_if.mem_req, mem_if.mem_addr, fetch_new_instruction); end
    serve(2, 32'h01000093, ok);
    tick();
    vectors++; if (!ok || fetch_new_instruction !== 1'b1 || inst_out !== 32'h01000093 || inst_pc !== 32'h100) begin
      miscompares++; $display("FAIL conf_issue: fetch %b inst %h pc %h want 1/01000093/100", fetch_new_instruction, inst_out, inst_pc); end
    park();
    pc_in = 32'h0;
    stop_fetching = 1'b0;
    tick();
    vectors++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 32'h0 || fetch_new_instruction !== 1'b0) begin
      miscompares++; $display("FAIL conf_evicted: req %b addr %h fetch %b want 1/0/0", mem_if.mem_req, mem_if.mem_addr, fetch_new_instruction); end
    serve(1, 32'h00500093, ok);
    tick();
    vectors++; if (!ok || fetch_new_instruction !== 1'b1 || inst_out !== 32'h00500093) begin
      miscompares++; $display("FAIL conf_refill: fetch %b inst %h want 1/00500093", fetch_new_instruction, inst_out); end
    stop_fetching = 1'b1;
  endtask

  task automatic test_reset_mid_miss_and_rdy;
    bit ok;
    park();
    pc_in = 32'hC;
    stop_fetching = 1'b0;
    tick();
    vectors++; if (mem_if.mem_req !== 1'b1) begin miscompares++; $display("FAIL rst_pre_req: got %b want 1", mem_if.mem_req); end
    #1 rst_in = 1'b1;
    #1;
    vectors++; if (mem_if.mem_req !== 1'b0 || mem_if.mem_addr !== 32'h0 || fetch_new_instruction !== 1'b0 || inst_out !== 32'h0 || inst_pc !== 32'h0) begin
      miscompares++; $display("FAIL rst_async: req %b addr %h fetch %b inst %h pc %h want all 0", mem_if.mem_req, mem_if.mem_addr, fetch_new_instruction, inst_out, inst_pc); end
    tick();
    rst_in = 1'b0;
    pc_in = 32'h4;
    tick();
    vectors++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 32'h4 || fetch_new_instruction !== 1'b0) begin
      miscompares++; $display("FAIL rst_cold_again: req %b addr %h fetch %b want 1/4/0", mem_if.mem_req, mem_if.mem_addr, fetch_new_instruction); end
    serve(1, 32'h00100113, ok);
    tick();
    vectors++; if (!ok || fetch_new_instruction !== 1'b1 || inst_pc !== 32'h4) begin miscompares++; $display("FAIL rst_refill: fetch %b pc %h want 1/4", fetch_new_instruction, inst_pc); end
    rdy_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++; if (fetch_new_instruction !== 1'b1 || inst_pc !== 32'h4 || inst_out !== 32'h00100113 || mem_if.mem_req !== 1'b0) begin
        miscompares++; $display("FAIL rdy_freeze c%0d: fetch %b pc %h inst %h req %b want 1/4/00100113/0", c, fetch_new_instruction, inst_pc, inst_out, mem_if.mem_req); end
    end
    rdy_in = 1'b1;
    stop_fetching = 1'b1;
    tick();
    vectors++; if (fetch_new_instruction !== 1'b0) begin miscompares++; $display("FAIL rdy_single_issue: got %b want 0", fetch_new_instruction); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit_streaming();
    test_stall();
    test_roll_back_idle();
    test_roll_back_miss();
    test_conflict();
    test_reset_mid_miss_and_rdy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule
